// File: rtl/mux5_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux5_pkg
//  Description : Shared types and constants for the five-source round-robin
//                mux scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux5_pkg;

    localparam int          NUM_SRC  = 5;
    localparam logic [2:0]  SEL_IDLE = 3'd7;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef logic [2:0] sel_t;

    // Index following i in the ring of sources; source 4 wraps back to 0.
    function automatic sel_t next_idx(input sel_t i);
        return (i >= sel_t'(NUM_SRC - 1)) ? 3'd0 : i + 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick5.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick5
//  Description : Rotating-priority search over five request lines. Returns the
//                first asserted request at or after 'start', modulo 5.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick5
    import mux5_pkg::*;
(
    input  logic [4:0] req,
    input  sel_t       start,
    output logic       found,
    output sel_t       idx
);

    logic [9:0] w_req2;
    sel_t       w_start;
    logic [3:0] w_pos;

    // Doubling the request vector turns the modulo walk into a linear scan.
    assign w_req2  = {req, req};
    assign w_start = (start > 3'd4) ? 3'd0 : start;

    // Scan five consecutive positions from the start index; first hit wins.
    always_comb begin
        found = 1'b0;
        idx   = SEL_IDLE;
        w_pos = 4'd0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_pos = {1'b0, w_start} + 4'(k);
            if (!found && w_req2[w_pos]) begin
                found = 1'b1;
                idx   = (w_pos >= 4'd5) ? 3'(w_pos - 4'd5) : w_pos[2:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux5_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : mux5_rr_scheduler
//  Description : Round-robin owner of a 5-to-1 source mux. Grants are bounded
//                to HOLD cycles; the select parks on code 7 while idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux5_rr_scheduler
    import mux5_pkg::*;
#(
    parameter int HOLD = 4
)(
    input  logic       Clock,
    input  logic       Reset,
    input  logic [4:0] Req,
    output sel_t       Sel,
    output logic [4:0] Grant,
    output logic       Busy,
    output logic [3:0] Count
);

    localparam logic [3:0] c_HOLD_LAST = 4'(HOLD - 1);

    state_t     r_state, w_state_nxt;
    sel_t       r_sel,   w_sel_nxt;
    logic [4:0] r_grant, w_grant_nxt;
    logic       r_busy,  w_busy_nxt;
    logic [3:0] r_count, w_count_nxt;
    sel_t       r_ptr,   w_ptr_nxt;

    sel_t       w_rel_ptr;
    sel_t       w_start;
    logic       w_found;
    sel_t       w_idx;
    logic       w_owner_req;
    logic       w_release;

    // On release the search starts just past the current owner; in IDLE it
    // starts at the stored pointer. One picker serves both cases.
    assign w_rel_ptr   = next_idx(r_sel);
    assign w_start     = (r_state == GRANT) ? w_rel_ptr : r_ptr;
    // Grant is one-hot, so masking avoids indexing Req with the idle code.
    assign w_owner_req = |(Req & r_grant);
    assign w_release   = (r_state == GRANT) &&
                         (!w_owner_req || (r_count == c_HOLD_LAST));

    rr_pick5 u_pick (
        .req   (Req),
        .start (w_start),
        .found (w_found),
        .idx   (w_idx)
    );

    // Next state and next registered outputs; everything holds by default.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_grant_nxt = r_grant;
        w_busy_nxt  = r_busy;
        w_count_nxt = r_count;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = GRANT;
                    w_sel_nxt   = w_idx;
                    w_grant_nxt = 5'd1 << w_idx;
                    w_busy_nxt  = 1'b1;
                    w_count_nxt = 4'd0;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_ptr_nxt = w_rel_ptr;
                    if (w_found) begin
                        w_sel_nxt   = w_idx;
                        w_grant_nxt = 5'd1 << w_idx;
                        w_busy_nxt  = 1'b1;
                        w_count_nxt = 4'd0;
                    end else begin
                        w_state_nxt = IDLE;
                        w_sel_nxt   = SEL_IDLE;
                        w_grant_nxt = 5'd0;
                        w_busy_nxt  = 1'b0;
                        w_count_nxt = 4'd0;
                    end
                end else begin
                    w_count_nxt = r_count + 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_sel_nxt   = SEL_IDLE;
                w_grant_nxt = 5'd0;
                w_busy_nxt  = 1'b0;
                w_count_nxt = 4'd0;
            end
        endcase
    end

    // State, pointer and output registers; Reset forces idle immediately.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_sel   <= SEL_IDLE;
            r_grant <= 5'd0;
            r_busy  <= 1'b0;
            r_count <= 4'd0;
            r_ptr   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_grant <= w_grant_nxt;
            r_busy  <= w_busy_nxt;
            r_count <= w_count_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign Sel   = r_sel;
    assign Grant = r_grant;
    assign Busy  = r_busy;
    assign Count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mux5_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux5_rr_scheduler
//  Description : Self-checking bench for mux5_rr_scheduler (HOLD=4 and HOLD=1
//                instances) using queued expected output tuples.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux5_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] req  = 5'd0;
    logic [4:0] req1 = 5'd0;

    logic [2:0] sel,   sel1;
    logic [4:0] grant, grant1;
    logic       busy,  busy1;
    logic [3:0] count, count1;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected {sel, grant, busy, count} tuples
    logic [12:0] q[$];
    logic [12:0] q1[$];

    mux5_rr_scheduler #(.HOLD(4)) dut (
        .Clock (clk),
        .Reset (rst),
        .Req   (req),
        .Sel   (sel),
        .Grant (grant),
        .Busy  (busy),
        .Count (count)
    );

    mux5_rr_scheduler #(.HOLD(1)) dut1 (
        .Clock (clk),
        .Reset (rst),
        .Req   (req1),
        .Sel   (sel1),
        .Grant (grant1),
        .Busy  (busy1),
        .Count (count1)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] pack_exp(input logic [2:0] s, input logic b,
                                             input logic [3:0] c);
        logic [4:0] g;
        g = b ? (5'd1 << s) : 5'd0;
        return {s, g, b, c};
    endfunction

    task automatic do_reset();
        rst  = 1'b1;
        req  = 5'd0;
        req1 = 5'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] e, o;
        #2 rst = 1'b1;
        #2;
        q.push_back(pack_exp(3'd7, 1'b0, 4'd0));
        q1.push_back(pack_exp(3'd7, 1'b0, 4'd0));
        e = q.pop_front();
        o = {sel, grant, busy, count};
        n_checks++;
        if (o !== e) $display("FAIL reset_h4: got %b expected %b", o, e);
        else n_pass++;
        e = q1.pop_front();
        o = {sel1, grant1, busy1, count1};
        n_checks++;
        if (o !== e) $display("FAIL reset_h1: got %b expected %b", o, e);
        else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [12:0] e, o;
        do_reset();
        // grant source 2
        req = 5'b00100;
        q.push_back(pack_exp(3'd2, 1'b1, 4'd0));
        @(posedge clk); #1;
        e = q.pop_front(); o = {sel, grant, busy, count};
        n_checks++;
        if (o !== e) $display("FAIL reset_mid_grant: got %b expected %b", o, e);
        else n_pass++;
        // asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        q.push_back(pack_exp(3'd7, 1'b0, 4'd0));
        e = q.pop_front(); o = {sel, grant, busy, count};
        n_checks++;
        if (o !== e) $display("FAIL reset_mid_async: got %b expected %b", o, e);
        else n_pass++;
        #1 rst = 1'b0;
        q.push_back(pack_exp(3'd2, 1'b1, 4'd0));
        @(posedge clk); #1;
        e = q.pop_front(); o = {sel, grant, busy, count};
        n_checks++;
        if (o !== e) $display("FAIL reset_mid_regrant: got %b expected %b", o, e);
        else n_pass++;
        req = 5'b00000;
        q.push_back(pack_exp(3'd7, 1'b0, 4'd0));
        @(posedge clk); #1;
        e = q.pop_front(); o = {sel, grant, busy, count};
        n_checks++;
        if (o !== e) $display("FAIL reset_mid_idle: got %b expected %b", o, e);
        else n_pass++;
    endtask

    task automatic test_single();
        logic [12:0] e, o;
        logic [4:0]  reqs [3];
        logic [12:0] exps [3];
        do_reset();
        reqs = '{5'b00100, 5'b00100, 5'b00000};
        exps = '{pack_exp(3'd2, 1'b1, 4'd0), pack_exp(3'd2, 1'b1, 4'd1),
                 pack_exp(3'd7, 1'b0, 4'd0)};
        for (int i = 0; i < 3; i++) begin
            req = reqs[i];
            q.push_back(exps[i]);
            @(posedge clk); #1;
            e = q.pop_front(); o = {sel, grant, busy, count};
            n_checks++;
            if (o !== e) $display("FAIL single[%0d]: got %b expected %b", i, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_rotate();
        logic [12:0] e, o;
        do_reset();
        for (int n = 0; n < 21; n++) begin
            req = 5'b11111;
            q.push_back(pack_exp(3'((n / 4) % 5), 1'b1, 4'(n % 4)));
            @(posedge clk); #1;
            e = q.pop_front(); o = {sel, grant, busy, count};
            n_checks++;
            if (o !== e) $display("FAIL rotate[%0d]: got %b expected %b", n, o, e);
            else n_pass++;
        end
        req = 5'b00000;
        q.push_back(pack_exp(3'd7, 1'b0, 4'd0));
        @(posedge clk); #1;
        e = q.pop_front(); o = {sel, grant, busy, count};
        n_checks++;
        if (o !== e) $display("FAIL rotate_idle: got %b expected %b", o, e);
        else n_pass++;
    endtask

    task automatic test_sole_timeout();
        logic [12:0] e, o;
        do_reset();
        for (int n = 0; n < 10; n++) begin
            req = 5'b01000;
            q.push_back(pack_exp(3'd3, 1'b1, 4'(n % 4)));
            @(posedge clk); #1;
            e = q.pop_front(); o = {sel, grant, busy, count};
            n_checks++;
            if (o !== e) $display("FAIL sole[%0d]: got %b expected %b", n, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        logic [12:0] e, o;
        logic [4:0]  reqs [5];
        logic [12:0] exps [5];
        do_reset();
        reqs = '{5'b10000, 5'b10001, 5'b00001, 5'b10000, 5'b00000};
        exps = '{pack_exp(3'd4, 1'b1, 4'd0), pack_exp(3'd4, 1'b1, 4'd1),
                 pack_exp(3'd0, 1'b1, 4'd0), pack_exp(3'd4, 1'b1, 4'd0),
                 pack_exp(3'd7, 1'b0, 4'd0)};
        for (int i = 0; i < 5; i++) begin
            req = reqs[i];
            q.push_back(exps[i]);
            @(posedge clk); #1;
            e = q.pop_front(); o = {sel, grant, busy, count};
            n_checks++;
            if (o !== e) $display("FAIL wrap[%0d]: got %b expected %b", i, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_hold1();
        logic [12:0] e, o;
        do_reset();
        for (int n = 0; n < 6; n++) begin
            req1 = 5'b00110;
            q1.push_back(pack_exp((n % 2 == 0) ? 3'd1 : 3'd2, 1'b1, 4'd0));
            @(posedge clk); #1;
            e = q1.pop_front(); o = {sel1, grant1, busy1, count1};
            n_checks++;
            if (o !== e) $display("FAIL hold1[%0d]: got %b expected %b", n, o, e);
            else n_pass++;
        end
        req1 = 5'b00000;
        q1.push_back(pack_exp(3'd7, 1'b0, 4'd0));
        @(posedge clk); #1;
        e = q1.pop_front(); o = {sel1, grant1, busy1, count1};
        n_checks++;
        if (o !== e) $display("FAIL hold1_idle: got %b expected %b", o, e);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_single();
        test_rotate();
        test_sole_timeout();
        test_wrap();
        test_hold1();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Guard against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
